cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//  Lookup/miss sequencer for the 4-way set-associative cache. Compares the CPU tag against
//  the per-way tag arrays and keeps valid bits and true-LRU ages per set. On a miss it runs
//  the memory refill handshake, then drives tagWrite, the one-hot set decode and the miss
//  strobe into the chosen way's tag array. Sits between the CPU port and the tag/data arrays.
// PARAMETERS
//  TAG_W   25  tag bits per line (addr[31:7])
//  IDX_W   3   set index bits (addr[6:4]); SETS = 2**IDX_W = 8
//  OFF_W   4   byte offset bits (addr[3:0]); 16-byte lines
//  WAYS    4   associativity; power of 2; AGE_W = log2(WAYS) = 2
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  cpu_valid    in   1            CPU request valid
//  cpu_addr     in   32           request byte address; {tag, idx, off}
//  cpu_ready    out  1            request accepted this cycle (IDLE only)
//  cpu_done     out  1            1-cycle pulse: access complete (hit or refilled)
//  cpu_hit      out  1            with cpu_done: 1 = hit on first lookup, 0 = serviced by refill
//  cpu_way      out  log2(WAYS)   with cpu_done: way holding the line
//  tag_rd       in   WAYS*TAG_W   tags of all ways for set idx_q; way w at [w*TAG_W +: TAG_W]
//  tag_wdata    out  TAG_W        tag to write (registered request tag)
//  tagWrite     out  WAYS         one-hot way write enable
//  decOut1b     out  SETS         one-hot set decode of idx_q
//  miss         out  1            high in REFILL and UPDATE
//  mem_req      out  1            refill request; held until mem_ack
//  mem_addr     out  32           {tag_q, idx_q, OFF_W'b0}
//  mem_ack      in   1            1-cycle pulse: refill data delivered to data array
// BEHAVIOUR
//  States: IDLE, LOOKUP, REFILL, UPDATE. Reset (reset=0, async): state=IDLE; all valid=0;
//   age[s][w]=w; all outputs 0 except decOut1b = one-hot of idx 0.
//  IDLE: cpu_ready=1. cpu_valid=1 -> latch tag_q/idx_q, go LOOKUP. cpu_ready=0 elsewhere.
//  LOOKUP: hit = valid[idx][w] && tag_rd[w]==tag_q for some w (at most one; lowest index if
//   several). Hit: cpu_done=1, cpu_hit=1 (first lookup only), cpu_way=w, LRU touch, -> IDLE.
//   Miss: victim = lowest-index invalid way, else way with age==WAYS-1; latch victim -> REFILL.
//  REFILL: mem_req=1, mem_addr stable. mem_ack=1 -> UPDATE. mem_ack outside REFILL ignored.
//  UPDATE (exactly 1 cycle): tagWrite=one-hot(victim), tag_wdata=tag_q, valid[idx][victim]=1,
//   -> LOOKUP; re-lookup hits: cpu_done=1, cpu_hit=0, cpu_way=victim.
//  Latency: hit = done 1 cycle after accept; miss = done 2 cycles after mem_ack.
//  LRU touch of way w in set s: ages < age[w] increment by 1, age[w]=0; other sets unchanged.
//   Ages stay a permutation of 0..WAYS-1 at all times; saturation never reached.
//  decOut1b tracks idx_q combinationally; tagWrite is zero outside UPDATE.
//  cpu_valid held during a busy state is not sampled until the return to IDLE.
//  Reset mid-refill: abort immediately; mem_req drops asynchronously; no tag written.
// STRUCTURE
//  Package cache_pkg: TAG_W/IDX_W/OFF_W/WAYS localparams, state enum, addr field slices.
//  Sub-module lru_set_ages: age regs for all sets, touch port (set, way) and victim-select
//   output; controller holds FSM, valid array, compare and victim latch.
// TESTING
//  1 Cold miss: reset, read 0x0000_0040 -> mem_req with mem_addr 0x0000_0040; ack ->
//    tagWrite=4'b0001, decOut1b=8'h10, tag_wdata=0; next cycle done, hit=0, way=0.
//  2 Re-read 0x0000_0044 (tag_rd returns the tag written) -> done 1 cycle after accept,
//    hit=1, way=0, no mem_req.
//  3 Fill set 4 with tags 1..4 (ways 0..3), touch tag 1 again, miss tag 5 -> victim way 1
//    (age 3); tagWrite=4'b0010.
//  4 mem_ack held 0 for 10 cycles -> mem_req/mem_addr stable, cpu_ready=0, no tagWrite.
//  5 reset=0 in REFILL -> IDLE, mem_req=0 same cycle, all valid cleared; next access misses.
//  6 Alternate sets 0 and 7 -> only indexed set's ages change; decOut1b = 8'h01 / 8'h80.

Source files
------------

// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the 4-way set-associative cache lookup/miss sequencer.
// Holds the geometry localparams, the controller state enum, the field types
// and the helpers that slice a CPU byte address into tag and set index.
package cache_miss_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 25;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 4;
  localparam int WAYS   = 4;
  localparam int SETS   = 2 ** IDX_W;
  localparam int AGE_W  = $clog2(WAYS);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [AGE_W-1:0]  way_t;
  typedef logic [AGE_W-1:0]  age_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  function automatic tag_t addr_tag(input addr_t addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t addr);
    return addr[OFF_W +: IDX_W];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Bundle of all non-clock/reset signals of cache_miss_ctrl.
//   CPU side : cpu_valid, cpu_addr -> ; <- cpu_ready, cpu_done, cpu_hit, cpu_way
//   Tag array: tag_rd -> ; <- tag_wdata, tagWrite, decOut1b, miss
//   Memory   : mem_ack -> ; <- mem_req, mem_addr
// The slave modport is the controller's view; master is the environment
// (CPU, tag arrays and memory) driving the controller.
interface cache_miss_ctrl_if;
  import cache_miss_ctrl_pkg::*;

  logic                  cpu_valid;
  addr_t                 cpu_addr;
  logic                  cpu_ready;
  logic                  cpu_done;
  logic                  cpu_hit;
  way_t                  cpu_way;
  logic [WAYS*TAG_W-1:0] tag_rd;
  tag_t                  tag_wdata;
  logic [WAYS-1:0]       tagWrite;
  logic [SETS-1:0]       decOut1b;
  logic                  miss;
  logic                  mem_req;
  addr_t                 mem_addr;
  logic                  mem_ack;

  modport slave (
    input  cpu_valid, cpu_addr, tag_rd, mem_ack,
    output cpu_ready, cpu_done, cpu_hit, cpu_way,
           tag_wdata, tagWrite, decOut1b, miss, mem_req, mem_addr
  );

  modport master (
    output cpu_valid, cpu_addr, tag_rd, mem_ack,
    input  cpu_ready, cpu_done, cpu_hit, cpu_way,
           tag_wdata, tagWrite, decOut1b, miss, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_miss_ctrl_lru.sv
// True-LRU age storage for every set of the cache.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   touch_en/set/way      mark way as most recently used in that set
//   vict_set -> vict_way  least recently used way (age == WAYS-1) of vict_set
// Ages per set are always a permutation of 0..WAYS-1; reset gives age[w] = w.
module lru_set_ages
  import cache_miss_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic touch_en,
  input  idx_t touch_set,
  input  way_t touch_way,
  input  idx_t vict_set,
  output way_t vict_way
);

  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;

  // Touch: everything younger than the touched way ages by one, the touched
  // way becomes 0. Older ways keep their age, so the permutation is preserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= age_t'(w);
        end
      end
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way_t'(w) == touch_way) begin
          age_q[touch_set][w] <= '0;
        end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
          age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    vict_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[vict_set][w] == age_t'(WAYS - 1)) begin
        vict_way = way_t'(w);
      end
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Lookup/miss sequencer for the 4-way set-associative cache.
// Compares the latched CPU tag against the per-way tags of the indexed set,
// keeps the valid bits, and on a miss runs the memory refill handshake and
// writes the victim way's tag array entry before re-looking the line up.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    cache_miss_ctrl_if.slave (CPU request/response, tag array
//          read/write/decode, memory refill handshake)
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  cache_miss_ctrl_if.slave   bus
);

  state_t                      state_q, state_d;
  tag_t                        tag_q;
  idx_t                        idx_q;
  way_t                        victim_q;
  logic                        refilled_q;
  logic [SETS-1:0][WAYS-1:0]   valid_q;

  logic hit_found;
  way_t hit_way;
  logic inv_found;
  way_t inv_way;
  way_t lru_way;
  way_t victim;
  logic accept;
  logic touch_en;

  // Tag compare; descending scan so the lowest matching way wins.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_q][w] && (bus.tag_rd[w*TAG_W +: TAG_W] == tag_q)) begin
        hit_found = 1'b1;
        hit_way   = way_t'(w);
      end
    end
  end

  // Victim choice: an empty way first, otherwise the least recently used.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = way_t'(w);
      end
    end
  end

  assign victim   = inv_found ? inv_way : lru_way;
  assign accept   = (state_q == S_IDLE) && bus.cpu_valid;
  assign touch_en = (state_q == S_LOOKUP) && hit_found;

  lru_set_ages u_lru (
    .clk       (clk),
    .reset     (reset),
    .touch_en  (touch_en),
    .touch_set (idx_q),
    .touch_way (hit_way),
    .vict_set  (idx_q),
    .vict_way  (lru_way)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cpu_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit_found ? S_IDLE : S_REFILL;
      S_REFILL: if (bus.mem_ack) state_d = S_UPDATE;
      S_UPDATE: state_d = S_LOOKUP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs. cpu_ready is gated by reset so every handshake output reads 0
  // while reset is held, even though the state already sits in IDLE.
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.cpu_hit   = 1'b0;
    bus.cpu_way   = '0;
    bus.tagWrite  = '0;
    bus.miss      = 1'b0;
    bus.mem_req   = 1'b0;
    case (state_q)
      S_IDLE: bus.cpu_ready = reset;
      S_LOOKUP: begin
        if (hit_found) begin
          bus.cpu_done = 1'b1;
          bus.cpu_hit  = !refilled_q;
          bus.cpu_way  = hit_way;
        end
      end
      S_REFILL: begin
        bus.miss    = 1'b1;
        bus.mem_req = 1'b1;
      end
      S_UPDATE: begin
        bus.miss     = 1'b1;
        bus.tagWrite = WAYS'(1) << victim_q;
      end
      default: ;
    endcase
  end

  assign bus.decOut1b  = SETS'(1) << idx_q;
  assign bus.tag_wdata = tag_q;
  assign bus.mem_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};

  // Request latch, victim latch, refill marker and valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q      <= '0;
      idx_q      <= '0;
      victim_q   <= '0;
      refilled_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      if (accept) begin
        tag_q      <= addr_tag(bus.cpu_addr);
        idx_q      <= addr_idx(bus.cpu_addr);
        refilled_q <= 1'b0;
      end
      if ((state_q == S_LOOKUP) && !hit_found) begin
        victim_q <= victim;
      end
      if (state_q == S_UPDATE) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        refilled_q               <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
  import cache_miss_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_miss_ctrl_if bus();

  cache_miss_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic hit;
    way_t way;
  } exp_t;
  exp_t sb_q[$];

  // Tag array model: read port follows the set of the request in flight,
  // write port uses the DUT's set decode and way enables.
  tag_t tb_tags [SETS][WAYS] = '{default: '0};
  idx_t cur_idx = '0;

  always_comb begin
    bus.tag_rd = '0;
    for (int w = 0; w < WAYS; w++) begin
      bus.tag_rd[w*TAG_W +: TAG_W] = tb_tags[cur_idx][w];
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.decOut1b[s] && bus.tagWrite[w]) tb_tags[s][w] <= bus.tag_wdata;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed access is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.cpu_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done: got done with empty queue, expected none");
      end else begin
        e = sb_q.pop_front();
        chk("sb_hit", 64'(bus.cpu_hit), 64'(e.hit));
        chk("sb_way", 64'(bus.cpu_way), 64'(e.way));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cpu_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("cpu_ready", 64'(bus.cpu_ready), 64'd1);
  endtask

  task automatic do_access(input addr_t addr, input logic exp_hit, input way_t exp_way,
                           input int ack_delay);
    exp_t e;
    addr_t exp_maddr;
    exp_maddr = {addr[31:4], 4'b0};
    wait_ready();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = addr;
    cur_idx       = addr[6:4];
    e.hit = exp_hit;
    e.way = exp_way;
    sb_q.push_back(e);
    tick();
    bus.cpu_valid = 1'b0;
    if (exp_hit) begin
      @(negedge clk);
      chk("hit_done_lat", 64'(bus.cpu_done), 64'd1);
      chk("hit_no_memreq", 64'(bus.mem_req), 64'd0);
      tick();
    end else begin
      @(negedge clk);
      chk("miss_no_done", 64'(bus.cpu_done), 64'd0);
      tick();
      chk("mem_req", 64'(bus.mem_req), 64'd1);
      chk("mem_addr", 64'(bus.mem_addr), 64'(exp_maddr));
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        chk("refill_hold", {bus.mem_req, bus.cpu_ready, |bus.tagWrite, bus.mem_addr},
            {1'b1, 1'b0, 1'b0, exp_maddr});
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("tagWrite", 64'(bus.tagWrite), 64'(4'b0001 << exp_way));
      chk("decOut1b", 64'(bus.decOut1b), 64'(8'h01 << addr[6:4]));
      chk("tag_wdata", 64'(bus.tag_wdata), 64'(addr[31:7]));
      chk("update_miss_noreq", {bus.miss, bus.mem_req}, 2'b10);
      tick();
      @(negedge clk);
      chk("miss_done_lat", 64'(bus.cpu_done), 64'd1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.mem_ack   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {bus.cpu_ready, bus.cpu_done, bus.mem_req, bus.miss, bus.tagWrite},
        '0);
    chk("rst_decOut1b", 64'(bus.decOut1b), 64'h01);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Cold miss, then hit on the same line
    do_access(32'h0000_0040, 1'b0, 2'd0, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_ignored", {bus.mem_req, bus.cpu_ready}, 2'b01);
    do_access(32'h0000_0044, 1'b1, 2'd0, 0);

    // Slow memory: ack withheld for 10 cycles
    do_access(32'h0000_0100, 1'b0, 2'd0, 10);

    // Reset in the middle of a refill
    wait_ready();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_0200;
    cur_idx       = 3'd0;
    tick();
    bus.cpu_valid = 1'b0;
    tick();
    chk("rst_mid_req_before", 64'(bus.mem_req), 64'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_req_drop", {bus.mem_req, bus.cpu_ready, bus.miss, bus.tagWrite}, '0);
    chk("rst_mid_decOut1b", 64'(bus.decOut1b), 64'h01);
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_access(32'h0000_0100, 1'b0, 2'd0, 0);

    // Fill set 4, re-touch way 0, LRU victim must be way 1
    do_access(32'h0000_00C0, 1'b0, 2'd0, 0);
    do_access(32'h0000_0140, 1'b0, 2'd1, 0);
    do_access(32'h0000_01C0, 1'b0, 2'd2, 1);
    do_access(32'h0000_0240, 1'b0, 2'd3, 0);
    do_access(32'h0000_00C0, 1'b1, 2'd0, 0);
    do_access(32'h0000_02C0, 1'b0, 2'd1, 0);
    do_access(32'h0000_02C0, 1'b1, 2'd1, 0);

    // Interleave sets 0 and 7; set 7 traffic must not disturb set 0 ages
    do_access(32'h0000_0070, 1'b0, 2'd0, 0);
    do_access(32'h0000_0180, 1'b0, 2'd1, 0);
    do_access(32'h0000_00F0, 1'b0, 2'd1, 2);
    do_access(32'h0000_0280, 1'b0, 2'd2, 0);
    do_access(32'h0000_0070, 1'b1, 2'd0, 0);
    do_access(32'h0000_0300, 1'b0, 2'd3, 0);
    do_access(32'h0000_00F0, 1'b1, 2'd1, 0);
    do_access(32'h0000_0380, 1'b0, 2'd0, 0);

    repeat (2) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
